// File: rtl/rr_dispatcher.sv
// Round-robin fan-out: one valid/ready input stream spread over NUM_LANE one-entry
// output registers, choosing the first free lane at or after a rotating pointer.
module rr_dispatcher #(
    parameter int unsigned NUM_LANE = 5,
    parameter int unsigned DATA_W   = 32,
    localparam int unsigned BW_LANE = $clog2(NUM_LANE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DATA_W-1:0]            i_data,
    output logic [NUM_LANE-1:0]          o_valid,
    input  logic [NUM_LANE-1:0]          i_ready,
    output logic [NUM_LANE*DATA_W-1:0]   o_data,
    output logic [BW_LANE-1:0]           o_accept_lane
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    localparam int unsigned BW_IDX = BW_LANE + 1;

    logic [NUM_LANE-1:0]              r_valid;
    logic [NUM_LANE-1:0][DATA_W-1:0]  r_data;
    logic [BW_LANE-1:0]               r_ptr;

    logic [NUM_LANE-1:0]              w_free;
    logic [NUM_LANE-1:0]              w_load;
    logic [BW_IDX-1:0]                w_sum;
    logic [BW_LANE-1:0]               w_sel;
    logic                             w_found;
    logic                             w_accept;

    // A lane being drained this cycle can take a new item in the same cycle.
    assign w_free   = ~r_valid | i_ready;
    assign o_ready  = |w_free;
    assign w_accept = i_valid & o_ready;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int unsigned i = 0; i < NUM_LANE; i++) begin
            w_sum = {1'b0, r_ptr} + BW_IDX'(i);
            if (w_sum >= BW_IDX'(NUM_LANE)) begin
                w_sum = w_sum - BW_IDX'(NUM_LANE);
            end
            if (!w_found && w_free[w_sum[BW_LANE-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[BW_LANE-1:0];
            end
        end
    end

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < NUM_LANE; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= i_data;
                end else if (i_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_sel == BW_LANE'(NUM_LANE - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    assign o_valid       = r_valid;
    assign o_data        = r_data;
    assign o_accept_lane = w_sel;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-free lane model.
module tb_rr_dispatcher;

    localparam int NL = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [DW-1:0]   i_data = '0;
    logic [NL-1:0]   o_valid;
    logic [NL-1:0]   i_ready = '0;
    logic [NL*DW-1:0] o_data;
    logic [1:0]      o_accept_lane;

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Behavioural lane state.
    logic          m_valid [NL];
    logic [DW-1:0] m_data  [NL];
    int            m_ptr;

    rr_dispatcher #(.NUM_LANE(NL), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_accept_lane (o_accept_lane)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int k);
        return o_data[k*DW +: DW];
    endfunction

    // First free lane scanning ptr, ptr+1, ... modulo NL; -1 when all are blocked.
    function automatic int pick();
        for (int d = 0; d < NL; d++) begin
            int l = (m_ptr + d) % NL;
            if (!m_valid[l] || i_ready[l]) return l;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NL; k++) begin
                m_valid[k] <= 1'b0;
                m_data[k]  <= '0;
            end
            m_ptr <= 0;
        end else begin
            for (int k = 0; k < NL; k++) begin
                if (i_valid && pick() == k) begin
                    m_valid[k] <= 1'b1;
                    m_data[k]  <= i_data;
                end else if (i_ready[k]) begin
                    m_valid[k] <= 1'b0;
                end
            end
            if (i_valid && pick() >= 0) m_ptr <= (pick() + 1) % NL;
        end
    end

    always @(negedge clk) begin
        if (checking && rst_n) begin
            chk("model_ready", 64'(o_ready), 64'(pick() >= 0));
            chk("model_lane", 64'(o_accept_lane), 64'((pick() >= 0) ? pick() : 0));
            for (int k = 0; k < NL; k++) begin
                chk("model_valid", 64'(o_valid[k]), 64'(m_valid[k]));
                chk("model_data", 64'(lane(k)), 64'(m_data[k]));
            end
        end
    end

    // One cycle: apply inputs just after the edge, return at the following negedge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NL-1:0] r);
        @(posedge clk);
        #1;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'h0);
        chk("rst_data_lo", o_data[63:0], 64'h0);
        chk("rst_data_hi", o_data[127:64], 64'h0);
        i_valid = 1'b0;
        i_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(negedge clk);
        checking = 1'b1;
        chk("reset_valid", 64'(o_valid), 64'h0);
        chk("reset_ready", 64'(o_ready), 64'h1);
        chk("reset_lane", 64'(o_accept_lane), 64'h0);

        // All lanes ready: plain rotation 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 4'hF);
            chk("rot_ready", 64'(o_ready), 64'h1);
            chk("rot_lane", 64'(o_accept_lane), 64'(i % 4));
            if (i > 0) chk("rot_data", 64'(lane((i - 1) % 4)), 64'(32'h10 + 32'(i - 1)));
        end
        drive(1'b0, '0, 4'hF);
        chk("rot_last", 64'(lane(0)), 64'h14);

        // Backpressure fill: four loads then stall.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 4'h0);
            if (i < 4) begin
                chk("fill_ready", 64'(o_ready), 64'h1);
                chk("fill_lane", 64'(o_accept_lane), 64'(i));
            end else begin
                chk("stall_ready", 64'(o_ready), 64'h0);
            end
        end
        drive(1'b1, 32'hA4, 4'h0);
        chk("stall_ready2", 64'(o_ready), 64'h0);
        chk("stall_valid", 64'(o_valid), 64'hF);
        for (int k = 0; k < 4; k++) chk("stall_data", 64'(lane(k)), 64'(32'hA0 + 32'(k)));

        // Full, lane 2 drains and reloads in the same cycle.
        drive(1'b1, 32'h55, 4'b0100);
        chk("swap_lane", 64'(o_accept_lane), 64'h2);
        drive(1'b0, '0, 4'h0);
        chk("swap_valid", 64'(o_valid), 64'hF);
        chk("swap_d2", 64'(lane(2)), 64'h55);
        chk("swap_d0", 64'(lane(0)), 64'hA0);
        chk("swap_d3", 64'(lane(3)), 64'hA3);

        // ptr=3, lane 3 blocked: wraps to lane 0.
        drive(1'b1, 32'h66, 4'b0001);
        chk("wrap_lane", 64'(o_accept_lane), 64'h0);
        drive(1'b0, '0, 4'h0);
        chk("wrap_d0", 64'(lane(0)), 64'h66);

        // ptr=1, lane 1 blocked, lanes 2/3 draining: goes to lane 2, ptr then 3.
        drive(1'b1, 32'h77, 4'b1100);
        chk("skip_lane", 64'(o_accept_lane), 64'h2);
        drive(1'b1, 32'h88, 4'h0);
        chk("skip_valid", 64'(o_valid), 64'h7);
        chk("skip_d2", 64'(lane(2)), 64'h77);
        chk("ptr3_lane", 64'(o_accept_lane), 64'h3);
        drive(1'b0, '0, 4'h0);
        chk("ptr3_d3", 64'(lane(3)), 64'h88);

        // Async reset mid-stream; first accept afterwards lands on lane 0.
        drive(1'b1, 32'h99, 4'h0);
        do_reset();
        drive(1'b1, 32'hBB, 4'h0);
        chk("post_rst_lane", 64'(o_accept_lane), 64'h0);

        // Randomized traffic, with an occasional asynchronous reset pulse.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            i_valid = ($urandom_range(0, 9) < 7);
            i_data  = $urandom;
            i_ready = NL'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rand_rst_valid", 64'(o_valid), 64'h0);
                rst_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
